// File: rtl/mixer_param_bank.sv
// mixer_param_bank: parametrised mixer register store with a registered host read
// port and a valid/ready dump engine that streams every stored parameter.
module mixer_param_bank #(
    parameter int V_OSC    = 4,
    parameter int DW       = 8,
    parameter int NAME_LEN = 16,
    parameter int ADR_W    = ($clog2(V_OSC) + 4 < 5) ? 5 : $clog2(V_OSC) + 4
) (
    input  logic                       data_clk,
    input  logic                       reset_data,
    input  logic [1:0]                 bank_sel,
    input  logic [ADR_W-1:0]           adr,
    input  logic                       wr_en,
    input  logic [DW-1:0]              wr_data,
    output logic                       wr_ready,
    input  logic                       rd_en,
    output logic [DW-1:0]              rd_data,
    output logic                       rd_valid,
    input  logic                       dump_start,
    output logic                       dump_busy,
    output logic                       dump_valid,
    input  logic                       dump_ready,
    output logic [1:0]                 dump_bank,
    output logic [ADR_W-1:0]           dump_adr,
    output logic [DW-1:0]              dump_data,
    output logic                       dump_done,
    output logic [V_OSC*DW-1:0]        osc_lvl,
    output logic [V_OSC*DW-1:0]        osc_mod_out,
    output logic [V_OSC*DW-1:0]        osc_feedb_out,
    output logic [V_OSC*DW-1:0]        osc_pan,
    output logic [V_OSC*DW-1:0]        osc_mod_in,
    output logic [V_OSC*DW-1:0]        osc_feedb_in,
    output logic [DW-1:0]              m_vol,
    output logic [16*V_OSC*DW-1:0]     mat_buf1,
    output logic [16*V_OSC*DW-1:0]     mat_buf2,
    output logic [NAME_LEN*8-1:0]      patch_name
);
    localparam logic [1:0] B_COM = 2'd0;
    localparam logic [1:0] B_OSC = 2'd1;
    localparam logic [1:0] B_M1  = 2'd2;
    localparam int NMAT  = 16 * V_OSC;
    localparam int WORDS = 1 + NAME_LEN + 38 * V_OSC;
    localparam int NW    = (NAME_LEN > 1) ? $clog2(NAME_LEN) : 1;
    localparam int OW    = (V_OSC > 1) ? $clog2(V_OSC) : 1;
    localparam int MW    = $clog2(NMAT);
    localparam int IW    = $clog2(WORDS);
    localparam logic [DW-1:0] MID = DW'(1 << (DW - 2));

    typedef struct packed {
        logic          vol;
        logic          name;
        logic          osc;
        logic          mat;
        logic [NW-1:0] ni;
        logic [OW-1:0] oi;
        logic [2:0]    slot;
        logic [MW-1:0] mi;
    } dec_t;

    typedef struct packed {
        logic [1:0]       b;
        logic [ADR_W-1:0] a;
    } loc_t;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT, S_DONE} dump_state_t;

    // Per-osc slots 0..5 hold lvl, mod_out, feedb_out, pan, mod_in, feedb_in.
    logic [DW-1:0] par_q  [V_OSC][6];
    logic [DW-1:0] vol_q;
    logic [7:0]    name_q [NAME_LEN];
    logic [DW-1:0] mat1_q [NMAT];
    logic [DW-1:0] mat2_q [NMAT];

    dump_state_t   state_q, state_d;
    logic [IW-1:0] idx_q;
    logic          last;
    dec_t          host_dec;
    logic [DW-1:0] host_word, dump_word;
    loc_t          nxt;
    logic [1:0]    src_bank;
    logic [ADR_W-1:0] src_adr;
    logic          wr_fire;

    function automatic dec_t decode(input logic [ADR_W-1:0] a);
        dec_t d;
        int ai, o, k;
        ai = int'(a);
        o  = ai >> 4;
        k  = ai & 15;
        d  = '0;
        d.vol  = (ai == 1);
        d.name = (ai >= 16) && (ai < 16 + NAME_LEN);
        d.ni   = NW'(ai - 16);
        d.oi   = OW'(o);
        d.mi   = MW'(ai);
        d.mat  = (ai < NMAT);
        d.osc  = (o < V_OSC);
        case (k)
            2:       d.slot = 3'd0;
            3:       d.slot = 3'd1;
            4:       d.slot = 3'd2;
            7:       d.slot = 3'd3;
            10:      d.slot = 3'd4;
            11:      d.slot = 3'd5;
            default: d.osc  = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic [DW-1:0] fetch(input logic [1:0] b, input dec_t d);
        logic [DW-1:0] v;
        v = '0;
        case (b)
            B_COM: begin
                if (d.vol)       v = vol_q;
                else if (d.name) v = DW'(name_q[d.ni]);
            end
            B_OSC:   if (d.osc) v = par_q[d.oi][d.slot];
            B_M1:    if (d.mat) v = mat1_q[d.mi];
            default: if (d.mat) v = mat2_q[d.mi];
        endcase
        return v;
    endfunction

    // Successor of a dump location in patch-send order; never called on the last word.
    function automatic loc_t next_loc(input logic [1:0] b, input logic [ADR_W-1:0] a);
        loc_t r;
        int ai, o, na;
        logic [1:0] nb;
        ai = int'(a);
        o  = ai >> 4;
        nb = b;
        na = ai + 1;
        case (b)
            B_COM: begin
                if (ai == 1) na = 16;
                else if (ai == 15 + NAME_LEN) begin
                    nb = B_OSC;
                    na = 2;
                end
            end
            B_OSC: begin
                case (ai & 15)
                    4, 7: na = ai + 3;
                    11: begin
                        if (o == V_OSC - 1) begin
                            nb = B_M1;
                            na = 0;
                        end else begin
                            na = ai + 7;
                        end
                    end
                    default: na = ai + 1;
                endcase
            end
            B_M1: begin
                if (ai == NMAT - 1) begin
                    nb = 2'd3;
                    na = 0;
                end
            end
            default: na = ai + 1;
        endcase
        r.b = nb;
        r.a = ADR_W'(na);
        return r;
    endfunction

    assign host_dec  = decode(adr);
    assign host_word = fetch(bank_sel, host_dec);
    assign wr_ready  = !dump_busy;
    assign wr_fire   = wr_en && wr_ready;

    always_ff @(posedge data_clk) begin
        if (reset_data) begin
            for (int o = 0; o < V_OSC; o++) begin
                for (int s = 0; s < 6; s++) begin
                    par_q[o][s] <= (s == 3 || (s == 0 && o < 2)) ? MID : '0;
                end
            end
            vol_q <= MID;
            for (int n = 0; n < NAME_LEN; n++) name_q[n] <= 8'h20;
            for (int i = 0; i < NMAT; i++) begin
                mat1_q[i] <= '0;
                mat2_q[i] <= '0;
            end
        end else if (wr_fire) begin
            case (bank_sel)
                B_COM: begin
                    if (host_dec.vol)       vol_q <= wr_data;
                    else if (host_dec.name) name_q[host_dec.ni] <= wr_data[7:0];
                end
                B_OSC:   if (host_dec.osc) par_q[host_dec.oi][host_dec.slot] <= wr_data;
                B_M1:    if (host_dec.mat) mat1_q[host_dec.mi] <= wr_data;
                default: if (host_dec.mat) mat2_q[host_dec.mi] <= wr_data;
            endcase
        end
    end

    // Read samples before this edge's write lands, so a same-cycle write returns old data.
    always_ff @(posedge data_clk) begin
        if (reset_data) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= host_word;
        end
    end

    // Dump handshake: a word transfers on each edge where dump_valid && dump_ready;
    // while valid && !ready, dump_bank/adr/data hold and valid stays high.
    always_ff @(posedge data_clk) begin
        if (reset_data) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        dump_busy  = 1'b0;
        dump_valid = 1'b0;
        dump_done  = 1'b0;
        case (state_q)
            S_IDLE:  if (dump_start) state_d = S_FETCH;
            S_FETCH: begin
                dump_busy = 1'b1;
                state_d   = S_PRESENT;
            end
            S_PRESENT: begin
                dump_busy  = 1'b1;
                dump_valid = 1'b1;
                if (dump_ready && last) state_d = S_DONE;
            end
            S_DONE: begin
                dump_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign last      = (idx_q == IW'(WORDS - 1));
    assign nxt       = next_loc(dump_bank, dump_adr);
    assign src_bank  = (state_q == S_PRESENT) ? nxt.b : dump_bank;
    assign src_adr   = (state_q == S_PRESENT) ? nxt.a : dump_adr;
    assign dump_word = fetch(src_bank, decode(src_adr));

    always_ff @(posedge data_clk) begin
        if (reset_data) begin
            dump_bank <= '0;
            dump_adr  <= '0;
            dump_data <= '0;
            idx_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (dump_start) begin
                        dump_bank <= B_COM;
                        dump_adr  <= ADR_W'(1);
                        idx_q     <= '0;
                    end
                end
                S_FETCH: dump_data <= dump_word;
                S_PRESENT: begin
                    if (dump_ready && !last) begin
                        dump_bank <= nxt.b;
                        dump_adr  <= nxt.a;
                        dump_data <= dump_word;
                        idx_q     <= idx_q + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    genvar go, gr, gn;
    generate
        for (go = 0; go < V_OSC; go++) begin : g_osc
            assign osc_lvl[go*DW +: DW]       = par_q[go][0];
            assign osc_mod_out[go*DW +: DW]   = par_q[go][1];
            assign osc_feedb_out[go*DW +: DW] = par_q[go][2];
            assign osc_pan[go*DW +: DW]       = par_q[go][3];
            assign osc_mod_in[go*DW +: DW]    = par_q[go][4];
            assign osc_feedb_in[go*DW +: DW]  = par_q[go][5];
            // Storage is address-ordered (o-major); the packed buses are r-major.
            for (gr = 0; gr < 16; gr++) begin : g_mat
                assign mat_buf1[(gr*V_OSC+go)*DW +: DW] = mat1_q[go*16+gr];
                assign mat_buf2[(gr*V_OSC+go)*DW +: DW] = mat2_q[go*16+gr];
            end
        end
        for (gn = 0; gn < NAME_LEN; gn++) begin : g_name
            assign patch_name[gn*8 +: 8] = name_q[gn];
        end
    endgenerate

    assign m_vol = vol_q;

endmodule

// File: tb/tb_mixer_param_bank.sv
// Directed bench for mixer_param_bank: reset map, host writes/reads, and dump streaming.
module tb_mixer_param_bank;
  localparam int V_OSC = 4;
  localparam int DW = 8;
  localparam int NAME_LEN = 16;
  localparam int ADR_W = 6;
  localparam int WORDS = 169;

  logic data_clk = 1'b0;
  logic reset_data;
  logic [1:0] bank_sel;
  logic [ADR_W-1:0] adr;
  logic wr_en;
  logic [DW-1:0] wr_data;
  logic wr_ready;
  logic rd_en;
  logic [DW-1:0] rd_data;
  logic rd_valid;
  logic dump_start;
  logic dump_busy;
  logic dump_valid;
  logic dump_ready;
  logic [1:0] dump_bank;
  logic [ADR_W-1:0] dump_adr;
  logic [DW-1:0] dump_data;
  logic dump_done;
  logic [V_OSC*DW-1:0] osc_lvl, osc_mod_out, osc_feedb_out, osc_pan, osc_mod_in, osc_feedb_in;
  logic [DW-1:0] m_vol;
  logic [16*V_OSC*DW-1:0] mat_buf1, mat_buf2;
  logic [NAME_LEN*8-1:0] patch_name;

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl [4][64];
  logic [15:0] exp_q[$];

  mixer_param_bank #(.V_OSC(V_OSC), .DW(DW), .NAME_LEN(NAME_LEN), .ADR_W(ADR_W)) dut (
    .data_clk(data_clk), .reset_data(reset_data), .bank_sel(bank_sel), .adr(adr),
    .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .dump_start(dump_start), .dump_busy(dump_busy),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_bank(dump_bank),
    .dump_adr(dump_adr), .dump_data(dump_data), .dump_done(dump_done),
    .osc_lvl(osc_lvl), .osc_mod_out(osc_mod_out), .osc_feedb_out(osc_feedb_out),
    .osc_pan(osc_pan), .osc_mod_in(osc_mod_in), .osc_feedb_in(osc_feedb_in),
    .m_vol(m_vol), .mat_buf1(mat_buf1), .mat_buf2(mat_buf2), .patch_name(patch_name)
  );

  // clock / reset
  always #5 data_clk = ~data_clk;

  task automatic tick();
    @(posedge data_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model of stored contents, indexed [bank][adr]
  task automatic model_reset();
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 64; a++) mdl[b][a] = 8'h00;
    mdl[0][1] = 8'h40;
    for (int n = 0; n < NAME_LEN; n++) mdl[0][16+n] = 8'h20;
    for (int o = 0; o < V_OSC; o++) begin
      mdl[1][o*16+2] = (o < 2) ? 8'h40 : 8'h00;
      mdl[1][o*16+7] = 8'h40;
    end
  endtask

  task automatic check_reset_outputs(input string p);
    chk({p, "_lvl"}, osc_lvl, 32'h0000_4040);
    chk({p, "_pan"}, osc_pan, 32'h4040_4040);
    chk({p, "_modout"}, osc_mod_out | osc_feedb_out | osc_mod_in | osc_feedb_in, 32'h0);
    chk({p, "_vol"}, m_vol, 8'h40);
    chk({p, "_name"}, 32'(patch_name == {16{8'h20}}), 1);
    chk({p, "_m1"}, 32'(mat_buf1 == '0), 1);
    chk({p, "_m2"}, 32'(mat_buf2 == '0), 1);
    chk({p, "_busy"}, dump_busy, 0);
    chk({p, "_dvalid"}, dump_valid, 0);
    chk({p, "_done"}, dump_done, 0);
  endtask

  // driver tasks
  task automatic do_write(input logic [1:0] b, input logic [5:0] a, input logic [7:0] d);
    bank_sel = b; adr = a; wr_data = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] b, input logic [5:0] a, output logic [7:0] d,
                         output logic v);
    bank_sel = b; adr = a; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    d = rd_data;
    v = rd_valid;
  endtask

  task automatic build_exp();
    int ks[6] = '{2, 3, 4, 7, 10, 11};
    logic [5:0] a6;
    exp_q.delete();
    exp_q.push_back({2'd0, 6'd1, mdl[0][1]});
    for (int n = 0; n < NAME_LEN; n++) begin
      a6 = 6'(16 + n);
      exp_q.push_back({2'd0, a6, mdl[0][a6]});
    end
    for (int o = 0; o < V_OSC; o++)
      for (int j = 0; j < 6; j++) begin
        a6 = 6'(o * 16 + ks[j]);
        exp_q.push_back({2'd1, a6, mdl[1][a6]});
      end
    for (int m = 2; m < 4; m++)
      for (int o = 0; o < V_OSC; o++)
        for (int r = 0; r < 16; r++) begin
          a6 = 6'(o * 16 + r);
          exp_q.push_back({2'(m), a6, mdl[m][a6]});
        end
  endtask

  // scoreboard-driven dump run
  task automatic run_dump(input bit toggle, input int abort_at, input int write_at, input bit hand);
    int beats, cyc;
    bit stall, fin, wr_pending;
    logic [15:0] cur_w, prev_w, e;
    build_exp();
    dump_ready = 1'b1;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    chk("busy_fetch", dump_busy, 1);
    chk("valid_fetch", dump_valid, 0);
    chk("wr_ready_fetch", wr_ready, 0);
    beats = 0; cyc = 0; stall = 0; fin = 0; wr_pending = 0; prev_w = '0;
    while (cyc < 2000) begin
      tick();
      cyc++;
      dump_start = 1'b0;
      cur_w = {dump_bank, dump_adr, dump_data};
      if (fin) begin
        chk("done_pulse", dump_done, 1);
        chk("busy_done", dump_busy, 0);
        chk("valid_done", dump_valid, 0);
        if (wr_pending) begin
          chk("wr_ready_done", wr_ready, 1);
          chk("lvl1_held", osc_lvl[15:8], 8'h40);
        end
        tick();
        if (wr_pending) begin
          wr_en = 1'b0;
          chk("lvl1_landed", osc_lvl[15:8], 8'h55);
          mdl[1][18] = 8'h55;
        end
        chk("done_once", dump_done, 0);
        break;
      end
      if (cyc == 1) chk("first_valid", dump_valid, 1);
      if (stall) begin
        chk("stall_valid", dump_valid, 1);
        chk("stall_stable", cur_w, prev_w);
      end
      if (wr_pending) chk("wr_blocked", wr_ready, 0);
      if (!toggle) chk("no_gap", dump_valid, 1);
      stall = 1'b0;
      if (dump_valid) begin
        if (beats == abort_at) begin
          reset_data = 1'b1;
          tick();
          reset_data = 1'b0;
          chk("abort_valid", dump_valid, 0);
          chk("abort_busy", dump_busy, 0);
          chk("abort_done", dump_done, 0);
          for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_done", dump_done, 0);
          end
          exp_q.delete();
          return;
        end
        if (beats == write_at) begin
          bank_sel = 2'd1; adr = 6'h12; wr_data = 8'h55; wr_en = 1'b1;
          wr_pending = 1'b1;
        end
        if (beats == 5) dump_start = 1'b1;
        dump_ready = toggle ? ((cyc % 3) != 1) : 1'b1;
        stall = !dump_ready;
        prev_w = cur_w;
        if (dump_ready) begin
          if (exp_q.size() == 0) begin
            chk("exp_underflow", 1, 0);
            break;
          end
          e = exp_q.pop_front();
          chk($sformatf("beat%0d", beats), cur_w, e);
          if (hand && beats == 0) chk("beat0_hand", cur_w, 16'h0140);
          if (hand && beats == 17) chk("beat17_hand", cur_w, 16'h4240);
          if (hand && beats == WORDS - 1) chk("beat_last_hand", cur_w, 16'hFF99);
          beats++;
          if (beats == WORDS) fin = 1'b1;
        end
      end
    end
    if (!fin) chk("dump_timeout", 0, 1);
    dump_ready = 1'b1;
  endtask

  initial begin
    logic [7:0] d;
    logic v;
    logic [6*32-1:0] snap;
    reset_data = 1'b1; bank_sel = '0; adr = '0; wr_en = 1'b0; wr_data = '0;
    rd_en = 1'b0; dump_start = 1'b0; dump_ready = 1'b1;
    model_reset();
    tick();
    tick();
    reset_data = 1'b0;
    check_reset_outputs("rst");
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_wr_ready", wr_ready, 1);

    // full read sweep of the reset map
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 64; a++) begin
        do_read(2'(b), 6'(a), d, v);
        chk($sformatf("rdv_b%0d_a%02h", b, a), v, 1);
        chk($sformatf("rd_b%0d_a%02h", b, a), d, mdl[b][a]);
      end
    tick();
    chk("rd_valid_idle", rd_valid, 0);
    chk("rd_data_hold", rd_data, mdl[3][63]);

    // osc writes, unmapped and read-only addresses
    do_write(2'd1, 6'h37, 8'h15);
    mdl[1][55] = 8'h15;
    chk("pan3_write", osc_pan[31:24], 8'h15);
    do_read(2'd1, 6'h37, d, v);
    chk("rd_pan3", d, 8'h15);
    snap = {osc_lvl, osc_mod_out, osc_feedb_out, osc_pan, osc_mod_in, osc_feedb_in};
    do_write(2'd1, 6'h05, 8'hAA);
    do_write(2'd1, 6'h3C, 8'h11);
    chk("unmapped_nochange",
        32'(snap == {osc_lvl, osc_mod_out, osc_feedb_out, osc_pan, osc_mod_in, osc_feedb_in}), 1);
    do_read(2'd1, 6'h05, d, v);
    chk("rd_osc05", d, 8'h00);
    do_read(2'd1, 6'h3C, d, v);
    chk("rd_osc3c", d, 8'h00);

    // same-cycle write and read returns the old value
    bank_sel = 2'd2; adr = 6'h21; wr_data = 8'h7F; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    mdl[2][33] = 8'h7F;
    chk("rw_same_valid", rd_valid, 1);
    chk("rw_same_old", rd_data, 8'h00);
    do_read(2'd2, 6'h21, d, v);
    chk("rw_next_new", d, 8'h7F);
    chk("mat1_r1_o2", mat_buf1[55:48], 8'h7F);

    // name boundaries and last matrix word
    do_write(2'd0, 6'd31, 8'h5A);
    mdl[0][31] = 8'h5A;
    chk("name15", patch_name[127:120], 8'h5A);
    do_write(2'd0, 6'd32, 8'h33);
    do_read(2'd0, 6'd32, d, v);
    chk("rd_com32", d, 8'h00);
    do_write(2'd3, 6'h3F, 8'h99);
    mdl[3][63] = 8'h99;
    chk("mat2_r15_o3", mat_buf2[511:504], 8'h99);

    // dumps
    run_dump(1'b0, -1, -1, 1'b1);
    run_dump(1'b1, -1, 10, 1'b0);
    run_dump(1'b0, 50, -1, 1'b0);
    model_reset();
    check_reset_outputs("abort");
    run_dump(1'b0, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mixer_param_bank.md
Name: mixer_param_bank

Overview:
- Parametrised successor to the mixer_2 MIDI controller register store.
- Holds the per-oscillator mixer levels/routing, master volume, patch name and two modulation matrices for V_OSC oscillators at DW-bit width.
- Adds a registered host read path with a valid strobe and a write-ready gate.
- Adds a sysex dump engine that streams every stored parameter over a valid/ready handshake for patch send.

Parameters:
- V_OSC, 4, oscillators per voice (1..8).
- DW, 8, parameter data width (>=8).
- NAME_LEN, 16, patch name characters (1..16).
- ADR_W, $clog2(V_OSC)+4, host address width (min 5).

Ports:
- data_clk  in  1  clock.
- reset_data  in  1  synchronous reset, active-high.
- bank_sel  in  2  target bank: 0=com, 1=osc, 2=m1, 3=m2.
- adr  in  ADR_W  host address within bank.
- wr_en  in  1  write strobe.
- wr_data  in  DW  write data.
- wr_ready  out  1  write accepted this cycle.
- rd_en  in  1  read strobe.
- rd_data  out  DW  read data.
- rd_valid  out  1  rd_data valid.
- dump_start  in  1  start dump, pulse.
- dump_busy  out  1  dump in progress.
- dump_valid  out  1  dump word valid.
- dump_ready  in  1  consumer accepts word.
- dump_bank  out  2  bank of current dump word.
- dump_adr  out  ADR_W  address of current dump word.
- dump_data  out  DW  current dump word.
- dump_done  out  1  one-cycle pulse after last word accepted.
- osc_lvl, osc_mod_out, osc_feedb_out, osc_pan, osc_mod_in, osc_feedb_in  out  V_OSC*DW each  packed per-osc params; osc o occupies [o*DW +: DW].
- m_vol  out  DW  master volume.
- mat_buf1, mat_buf2  out  16*V_OSC*DW each  matrix entry [r][o] at [(r*V_OSC+o)*DW +: DW].
- patch_name  out  NAME_LEN*8  character n at [n*8 +: 8].

Behaviour:
- Reset (reset_data high at clock edge):
  - osc_lvl[0], osc_lvl[1] = MID, where MID = 1<<(DW-2) (0x40 at DW=8); other osc_lvl = 0.
  - osc_pan = MID; m_vol = MID.
  - All other params, both matrices, rd_data = 0.
  - patch_name chars = 0x20.
  - rd_valid, dump_busy, dump_valid, dump_done = 0; dump FSM -> IDLE.
  - Reset mid-dump aborts without dump_done.
- Address map:
  - osc: adr = (o<<4)+k with k in {2:lvl, 3:mod_out, 4:feedb_out, 7:pan, 10:mod_in, 11:feedb_in}. k in 12..15 is read-only zero.
  - com: adr 1 = m_vol; adr 16+n = patch_name[n], n < NAME_LEN.
  - m1/m2: adr = (o<<4)+r, o < V_OSC, r < 16.
  - Any other address is unmapped: writes ignored, reads return 0.
- Writes:
  - wr_ready = !dump_busy (combinational).
  - Write takes effect at the edge when wr_en && wr_ready; the stored value is visible on outputs the next cycle.
  - patch_name stores wr_data[7:0].
  - While dump_busy, writes are dropped; the host must hold wr_en until wr_ready.
- Reads:
  - Latency 1: rd_en at cycle N gives rd_data/rd_valid at N+1.
  - rd_valid = 0 otherwise; rd_data holds its last value.
  - A read and a write to the same location in the same cycle returns the old value.
  - Reads are permitted during a dump.
- Dump FSM states: IDLE, FETCH, PRESENT, DONE.
  - IDLE: on dump_start -> FETCH and dump_busy = 1. dump_start while busy is ignored.
  - FETCH: registers the word at the current index -> PRESENT.
  - PRESENT: dump_valid = 1. Word advances only on dump_valid && dump_ready.
    - dump_data/bank/adr must stay stable while valid && !ready.
    - On acceptance: if more words remain, load the next word immediately (back-to-back, one word/cycle with dump_ready held high); else -> DONE.
  - DONE: dump_done = 1 for one cycle, busy = 0 -> IDLE.
  - First dump_valid appears 2 cycles after dump_start.
- Dump order:
  1. com adr 1.
  2. com adr 16..16+NAME_LEN-1.
  3. For o = 0..V_OSC-1: osc k = 2, 3, 4, 7, 10, 11.
  4. m1: o outer, r inner, adr = (o<<4)+r.
  5. m2: same order as m1.
- Word count = 1 + NAME_LEN + 6·V_OSC + 32·V_OSC (169 at defaults). The index counter must not wrap past the last word.
- Snapshot consistency is guaranteed because writes are blocked while dump_busy.

Test Plan:
- Reset, then read every address with V_OSC=4 -> osc_lvl0/1 = 0x40, lvl2/3 = 0, pans = 0x40, m_vol = 0x40, name = 0x20, all else 0, each with rd_valid one cycle after rd_en.
- Write osc bank adr 0x37 = 0x15, then read adr 0x37 -> osc_pan[3] = 0x15. Write osc adr 0x05 -> no register changes. Read osc adr 0x3C -> 0.
- Same-cycle wr_en + rd_en to m1 adr 0x21 with old=0, new=0x7F -> rd_data = 0x00; next read -> 0x7F; mat_buf1[1][2] = 0x7F.
- Dump with dump_ready held high -> 169 consecutive dump_valid beats. Beat 0 = (com, 1, 0x40); beat 17 = (osc, 0x02, 0x40); last = (m2, 0x3F, value). dump_done one cycle after the last accept.
- Dump with dump_ready toggled 1-0-1 and a write attempted mid-dump -> words stable while stalled, no duplicates or skips, wr_ready = 0, write lands only after dump_done.
- Assert reset_data at beat 50 of a dump -> dump_valid/busy = 0 next cycle, no dump_done, registers at reset values; a new dump_start restarts from beat 0.
